// File: rtl/main_memory_responder_pkg.sv
// mem_if_pkg: shared widths, field positions and state encoding for the memory responder
package mem_if_pkg;
   localparam int ADDR_W  = 24;
   localparam int DATA_W  = 64;
   localparam int PUSH_W  = 89;
   localparam int POP_W   = 88;
   localparam int WR_BIT  = 88;
   localparam int ADDR_HI = 87;
   localparam int ADDR_LO = 64;
   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;
   function automatic logic [ADDR_W-1:0] req_addr(input logic [PUSH_W-1:0] w);
      return w[ADDR_HI:ADDR_LO];
   endfunction
endpackage

// File: rtl/main_memory_responder_if.sv
// main_memory_responder_if: push/pop channel between the third-level cache FIFOs and main memory
interface main_memory_responder_if;
   import mem_if_pkg::*;
   logic [PUSH_W-1:0] D_PUSH;
   logic              Push_Valid;
   logic              Push_Ready;
   logic [POP_W-1:0]  D_POP;
   logic              Pop_Valid;
   logic              Pop_Ready;
   logic              Busy;
   modport master (output D_PUSH, Push_Valid, Pop_Ready, input Push_Ready, D_POP, Pop_Valid, Busy);
   modport slave  (input D_PUSH, Push_Valid, Pop_Ready, output Push_Ready, D_POP, Pop_Valid, Busy);
endinterface

// File: rtl/main_memory_responder_line_store.sv
// line_store: single-port synchronous line RAM with registered read, contents never reset
module line_store #(
   parameter int IDX_W  = 8,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**IDX_W];
   // write-first is not needed: a read always follows a committed write by at least one edge
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: services cache push requests against a line store after ACCESS_LAT cycles; MEM_WRITE_ACK_EN makes writes respond too
module main_memory_responder
   import mem_if_pkg::*;
#(
   parameter int ACCESS_LAT = 4,
   parameter int IDX_W      = 8
) (
   input logic CLK,
   input logic Reset,
   main_memory_responder_if.slave bus
);
   localparam int CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_LAT - 1);
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PUSH_W-1:0] req_q, req_d;
   logic [POP_W-1:0]  pop_q, pop_d;
   logic [IDX_W-1:0]  ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rd;
   line_store #(.IDX_W(IDX_W), .DATA_W(DATA_W)) u_store (
      .clk   (CLK),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (req_q[DATA_W-1:0]),
      .rdata (ram_rd)
   );
   assign bus.Push_Ready = (state_q == IDLE) && !Reset;
   assign bus.Pop_Valid  = state_q == RESPOND;
   assign bus.Busy       = state_q != IDLE;
   assign bus.D_POP      = pop_q;
   // next state; the RAM is addressed from D_PUSH while idle so the line is already read by the first ACCESS cycle
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      pop_d    = pop_q;
      ram_we   = 1'b0;
      ram_addr = (state_q == IDLE) ? bus.D_PUSH[ADDR_LO+3 +: IDX_W] : req_q[ADDR_LO+3 +: IDX_W];
      if (state_q == IDLE && bus.Push_Valid) begin
         req_d   = bus.D_PUSH;
         cnt_d   = CNT_INIT;
         state_d = ACCESS;
      end else if (state_q == ACCESS && cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else if (state_q == ACCESS) begin
         ram_we = req_q[WR_BIT];
`ifdef MEM_WRITE_ACK_EN
         pop_d   = {req_addr(req_q), req_q[WR_BIT] ? req_q[DATA_W-1:0] : ram_rd};
         state_d = RESPOND;
`else
         pop_d   = req_q[WR_BIT] ? pop_q : {req_addr(req_q), ram_rd};
         state_d = req_q[WR_BIT] ? IDLE : RESPOND;
`endif
      end else if (state_q == RESPOND && bus.Pop_Ready) begin
         state_d = IDLE;
      end
   end
   // state and request/response registers; reset drops any transaction in flight
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         pop_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         pop_q   <= pop_d;
      end
   end
endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: directed table, corner sequences and random traffic against a line-array model
module tb_main_memory_responder;
   localparam int LAT = 4;
`ifdef MEM_WRITE_ACK_EN
   localparam bit ACK = 1'b1;
`else
   localparam bit ACK = 1'b0;
`endif
   typedef struct {
      logic        wr;
      logic [23:0] addr;
      logic [63:0] data;
      logic [63:0] exp;
   } vec_t;
   logic CLK = 1'b0;
   logic Reset = 1'b1;
   int tests = 0;
   int fails = 0;
   logic [63:0] mdl [256];
   main_memory_responder_if bus();
   main_memory_responder #(.ACCESS_LAT(LAT), .IDX_W(8)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));
   always #5 CLK = ~CLK;
   function automatic int idx(input logic [23:0] a);
      return int'(a[10:3]);
   endfunction
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic xact(input logic wr, input logic [23:0] a, input logic [63:0] d,
                       output logic rv, output logic [87:0] resp, output int lat);
      int n;
      logic [95:0] junk;
      n = 0;
      rv = 1'b0;
      resp = '0;
      while (!bus.Push_Ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!bus.Push_Ready) check("push_ready_timeout", 0, 1);
      bus.D_PUSH = {wr, a, d};
      bus.Push_Valid = 1'b1;
      @(negedge CLK);
      bus.Push_Valid = 1'b0;
      junk = {$urandom, $urandom, $urandom};
      bus.D_PUSH = junk[88:0];
      lat = 0;
      while (lat < 50) begin
         @(negedge CLK);
         lat++;
         if (bus.Pop_Valid) begin
            rv = 1'b1;
            resp = bus.D_POP;
            break;
         end
         if (bus.Push_Ready) break;
      end
      if (rv) @(negedge CLK);
   endtask
   task automatic run(input string name, input logic wr, input logic [23:0] a,
                      input logic [63:0] d, input logic [63:0] exp);
      logic rv;
      logic [87:0] resp;
      int lat;
      xact(wr, a, d, rv, resp, lat);
      check({name, "_latency"}, 128'(lat), 128'(LAT));
      check({name, "_resp_valid"}, 128'(rv), 128'(!wr || ACK));
      if (!wr || ACK) check({name, "_dpop"}, 128'(resp), 128'({a, exp}));
      check({name, "_back_idle"}, 128'({bus.Push_Ready, bus.Busy, bus.Pop_Valid}), 128'(3'b100));
      if (wr) mdl[idx(a)] = d;
   endtask
   initial begin
      vec_t vecs [8];
      logic [87:0] held;
      logic [23:0] a;
      logic [63:0] d;
      logic w;
      foreach (mdl[i]) mdl[i] = '0;
      vecs[0] = '{1'b1, 24'h000010, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
      vecs[1] = '{1'b0, 24'h000010, 64'h0, 64'hDEADBEEF_CAFEF00D};
      vecs[2] = '{1'b1, 24'h000000, 64'h1234, 64'h1234};
      vecs[3] = '{1'b0, 24'h000800, 64'h0, 64'h1234};
      vecs[4] = '{1'b0, 24'h000018, 64'h0, 64'h0};
      vecs[5] = '{1'b1, 24'h000008, 64'hAA, 64'hAA};
      vecs[6] = '{1'b0, 24'hFFF00F, 64'h0, 64'hAA};
      vecs[7] = '{1'b0, 24'h000017, 64'h0, 64'hDEADBEEF_CAFEF00D};
      bus.D_PUSH = '0;
      bus.Push_Valid = 1'b0;
      bus.Pop_Ready = 1'b1;
      #2;
      check("in_reset_push_ready", 128'(bus.Push_Ready), 0);
      check("in_reset_pop_valid", 128'(bus.Pop_Valid), 0);
      repeat (3) @(negedge CLK);
      Reset = 1'b0;
      @(negedge CLK);
      check("reset_push_ready", 128'(bus.Push_Ready), 1);
      check("reset_pop_valid", 128'(bus.Pop_Valid), 0);
      check("reset_busy", 128'(bus.Busy), 0);
      check("reset_dpop", 128'(bus.D_POP), 0);
      foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);
      // backpressure: response held while Pop_Ready low, pushes ignored
      bus.Pop_Ready = 1'b0;
      bus.D_PUSH = {1'b0, 24'h000010, 64'h0};
      bus.Push_Valid = 1'b1;
      @(negedge CLK);
      bus.D_PUSH = {1'b1, 24'h000030, 64'hBAD0BAD0};
      repeat (LAT) @(negedge CLK);
      check("bp_pop_valid", 128'(bus.Pop_Valid), 1);
      check("bp_dpop", 128'(bus.D_POP), 128'({24'h000010, 64'hDEADBEEF_CAFEF00D}));
      held = bus.D_POP;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         check("bp_hold", 128'({bus.Pop_Valid, bus.Push_Ready, bus.Busy, bus.D_POP}), 128'({3'b101, held}));
      end
      bus.Push_Valid = 1'b0;
      bus.Pop_Ready = 1'b1;
      @(negedge CLK);
      check("bp_release", 128'({bus.Pop_Valid, bus.Push_Ready, bus.Busy}), 128'(3'b010));
      run("bp_ignored_write", 1'b0, 24'h000030, 64'h0, 64'h0);
      // reset two cycles into a write drops it
      bus.D_PUSH = {1'b1, 24'h000020, 64'h5555_6666_7777_8888};
      bus.Push_Valid = 1'b1;
      @(negedge CLK);
      bus.Push_Valid = 1'b0;
      repeat (2) @(negedge CLK);
      Reset = 1'b1;
      #1;
      check("midreset_outputs", 128'({bus.Pop_Valid, bus.Busy, bus.Push_Ready}), 0);
      check("midreset_dpop", 128'(bus.D_POP), 0);
      @(negedge CLK);
      Reset = 1'b0;
      @(negedge CLK);
      check("midreset_idle", 128'(bus.Push_Ready), 1);
      run("midreset_read", 1'b0, 24'h000020, 64'h0, 64'h0);
      // random traffic against the model
      for (int t = 0; t < 60; t++) begin
         a = 24'($urandom);
         a[10:3] = 8'($urandom_range(0, 7));
         d = {$urandom, $urandom};
         w = 1'($urandom_range(0, 1));
         run($sformatf("rnd%0d", t), w, a, d, w ? d : mdl[idx(a)]);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
